// File: rtl/mux_pkg.sv
// Shared encodings for the stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search with a rotating start pointer; the pointer moves past the winner on advance.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] request,
  input  logic                advance,
  output logic [SEL_W-1:0]    granted,
  output logic                grant_valid
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             hi_found;
  logic             lo_found;

  // Lowest requester at/above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (request[k]) begin
        lo_idx   = SEL_W'(k);
        lo_found = 1'b1;
        if (SEL_W'(k) >= rr_ptr) begin
          hi_idx   = SEL_W'(k);
          hi_found = 1'b1;
        end
      end
    end
    granted     = hi_found ? hi_idx : lo_idx;
    grant_valid = lo_found;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance && grant_valid) begin
      rr_ptr <= (granted == SEL_W'(CHANNELS - 1)) ? '0 : granted + SEL_W'(1);
    end
  end

endmodule

// File: rtl/stream_multiplexer.sv
// N-to-1 stream multiplexer with fixed or round-robin channel selection into a one-entry output register.
module stream_multiplexer
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_channel
);

  logic [SEL_W-1:0] rr_granted;
  logic             rr_valid;
  logic             fixed_valid;
  logic [SEL_W-1:0] granted;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic             load;

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .request    (in_valid),
    .advance    (load && (mode == MODE_RR)),
    .granted    (rr_granted),
    .grant_valid(rr_valid)
  );

  // Out-of-range selectors match no channel, so fixed_valid stays low.
  always_comb begin
    fixed_valid = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (selector == SEL_W'(k)) fixed_valid = in_valid[k];
    end
  end

  always_comb begin
    granted     = (mode == MODE_RR) ? rr_granted : selector;
    grant_valid = (mode == MODE_RR) ? rr_valid : fixed_valid;
    load        = grant_valid && (!out_valid || out_ready) && !reset;
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (granted == SEL_W'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = load;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      data_out    <= '0;
      out_channel <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      data_out    <= grant_data;
      out_channel <= granted;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_multiplexer.sv
// Directed vector bench for stream_multiplexer (4-channel and 3-channel instances).
module tb_stream_multiplexer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  selector;
  logic [3:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_channel;

  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  selector3;
  logic [3:0]  data_out3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_channel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_multiplexer #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .selector(selector), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel)
  );

  stream_multiplexer #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .selector(selector3), .data_out(data_out3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_channel(out_channel3)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_in_ready;
    logic       exp_ov;
    logic [3:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic m, input logic [1:0] s, input logic [3:0] v,
                         input logic r, input logic [3:0] ir, input logic ov,
                         input logic [3:0] d, input logic [1:0] ch);
    vecs[i] = '{m, s, v, r, ir, ov, d, ch};
  endtask

  initial begin
    // Channel data: ch3=D, ch2=A, ch1=5, ch0=3
    set_vec(0,  1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
    set_vec(1,  1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd2);
    set_vec(2,  1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1);
    set_vec(3,  1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0);
    set_vec(4,  1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1);
    set_vec(5,  1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
    set_vec(6,  1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    set_vec(7,  1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0);
    set_vec(8,  1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2); // ptr -> 3
    set_vec(9,  1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1); // wrap, ptr -> 2
    set_vec(10, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2); // ptr -> 3
    set_vec(11, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2);
    set_vec(12, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2);
    set_vec(13, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd2);
    set_vec(14, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd2);
    set_vec(15, 1'b1, 2'd0, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'hD, 2'd3); // ptr -> 0
    set_vec(16, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0); // ptr -> 1

    in_data   = 16'hDA53;
    in_valid  = '0;
    mode      = 1'b0;
    selector  = '0;
    out_ready = 1'b0;
    in_data3   = 12'hA53;
    in_valid3  = '0;
    mode3      = 1'b0;
    selector3  = '0;
    out_ready3 = 1'b0;
    reset = 1'b1;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset out_channel", 32'(out_channel), 32'd0);
    in_valid = 4'b1111;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clk);
      mode      = vecs[i].mode;
      selector  = vecs[i].sel;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ready;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("v%0d out_channel", i), 32'(out_channel), 32'(vecs[i].exp_ch));
    end

    // Reset between edges while a word is held
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset data_out", 32'(data_out), 32'd0);
    check("midreset out_channel", 32'(out_channel), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("held reset out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post reset rr_ptr grant", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post reset out_channel", 32'(out_channel), 32'd0);
    check("post reset data_out", 32'(data_out), 32'h3);

    // Three-channel instance: selector 3 is out of range
    @(negedge clk);
    mode3 = 1'b0; selector3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("oor in_ready c%0d", c), 32'(in_ready3), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("oor out_valid c%0d", c), 32'(out_valid3), 32'd0);
      @(negedge clk);
    end
    selector3 = 2'd2;
    #1;
    check("ch3 sel2 in_ready", 32'(in_ready3), 32'b100);
    @(posedge clk);
    #1;
    check("ch3 sel2 out_valid", 32'(out_valid3), 32'd1);
    check("ch3 sel2 data_out", 32'(data_out3), 32'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
